// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte/halfword/word access, programmable wait states,
// two-cycle ERROR responses and read-after-write forwarding. Optional macro: AHB_SRAM_BOUNDS_CHECK_EN.
module ahb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LANES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic [LANES-1:0]      r_mask;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic                  r_hreadyout;
  logic                  r_hresp;

  logic                  w_accept;
  logic                  w_err;
  logic [LANES-1:0]      w_mask;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_wr_done;
  logic [DATA_WIDTH-1:0] w_wr_word;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused;

  assign HRDATA    = r_hrdata;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

  // Upper address bits alias away when bounds checking is off.
  assign w_unused  = ^{HTRANS[0], HADDR};

  assign w_idx     = HADDR[IDX_W+1:2];
  assign w_accept  = HSEL & HREADY & HTRANS[1] & r_hreadyout;
  assign w_wr_done = (r_state == S_DATA) && r_write;

  always_comb begin
    w_err = 1'b0;
    case (HSIZE)
      3'd0:    w_err = 1'b0;
      3'd1:    w_err = HADDR[0];
      3'd2:    w_err = |HADDR[1:0];
      default: w_err = 1'b1;
    endcase
`ifdef AHB_SRAM_BOUNDS_CHECK_EN
    if (32'(HADDR[ADDR_WIDTH-1:2]) >= 32'(DEPTH)) w_err = 1'b1;
`endif
  end

  always_comb begin
    case (HSIZE)
      3'd0:    w_mask = LANES'(4'b0001 << HADDR[1:0]);
      3'd1:    w_mask = HADDR[1] ? LANES'(4'b1100) : LANES'(4'b0011);
      default: w_mask = LANES'(4'b1111);
    endcase
  end

  // Word as it stands after the completing write; also the forwarding source.
  always_comb begin
    w_wr_word = r_mem[r_idx];
    for (int i = 0; i < int'(LANES); i++) begin
      if (r_mask[i]) w_wr_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  assign w_rd_word = (w_wr_done && (r_idx == w_idx)) ? w_wr_word : r_mem[w_idx];

  always_ff @(posedge HCLK) begin
    if (w_wr_done) r_mem[r_idx] <= w_wr_word;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_mask      <= '0;
      r_hrdata    <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 may all start the next transfer on this edge.
          if (w_accept) begin
            r_idx   <= w_idx;
            r_mask  <= w_mask;
            r_write <= HWRITE & ~w_err;
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end else begin
              r_state     <= S_WAIT;
              r_cnt       <= 3'(WAIT_STATES - 1);
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end
            if (!HWRITE && !w_err) r_hrdata <= w_rd_word;
          end else begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one instance with zero wait states, one with two.
module tb_ahb_sram_slave;

  typedef struct packed {
    logic        is_read;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        hrst      [2];
  logic        hsel      [2];
  logic [11:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(hrst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HREADY(hreadyout[0]), .HWDATA(hwdata[0]),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
  );

  ahb_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) u_dut1 (
    .HCLK(clk), .HRESET(hrst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HREADY(hreadyout[1]), .HWDATA(hwdata[1]),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
  );

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Watches one bus: tracks accepted address phases, pops on the completing cycle.
  task automatic mon(input int d);
    bit   active = 1'b0;
    int   waits  = 0;
    logic resp_w = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (hrst[d]) begin
        active = 1'b0;
        continue;
      end
      if (active) begin
        if (!hreadyout[d]) begin
          if (waits == 0) resp_w = hresp[d];
          waits++;
        end else begin
          if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected completion: got a response, expected none", d);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d wait_cycles", d), 32'(waits), e.err ? 32'd1 : 32'(ws(d)));
            chk($sformatf("dut%0d hresp", d), 32'(hresp[d]), 32'(e.err));
            if (waits > 0) chk($sformatf("dut%0d hresp_first", d), 32'(resp_w), 32'(e.err));
            if (e.is_read && !e.err) chk($sformatf("dut%0d hrdata", d), hrdata[d], e.rdata);
          end
          active = 1'b0;
        end
      end
      if (hreadyout[d] && hsel[d] && htrans[d][1]) begin
        active = 1'b1;
        waits  = 0;
      end
    end
  endtask

  task automatic wait_ready(input int d, input string what);
    int budget = 20;
    @(negedge clk);
    while (!hreadyout[d] && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d %s timeout: got HREADYOUT=0, expected 1", d, what);
    end
    @(posedge clk);
    #1;
  endtask

  // Issues one address phase; returns just after the accepting edge with HWDATA driven.
  task automatic xfer(input int d, input logic [11:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input bit push);
    exp_t e;
    hsel[d]   = 1'b1;
    haddr[d]  = a;
    htrans[d] = 2'b10;
    hwrite[d] = w;
    hsize[d]  = sz;
    wait_ready(d, "accept");
    e.is_read = ~w;
    e.err     = exp_err;
    e.rdata   = exp_rd;
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    hwdata[d] = w ? wd : 32'h0;
  endtask

  task automatic idle(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    haddr[d]  = 12'h0;
    wait_ready(d, "complete");
  endtask

  task automatic wr(input int d, input logic [11:0] a, input logic [2:0] sz, input logic [31:0] wd,
                    input logic err);
    xfer(d, a, 1'b1, sz, wd, 32'h0, err, 1'b1);
    idle(d);
  endtask

  task automatic rd(input int d, input logic [11:0] a, input logic [31:0] exp_rd, input logic err);
    xfer(d, a, 1'b0, 3'd2, 32'h0, exp_rd, err, 1'b1);
    idle(d);
  endtask

  // Starts a transfer and pulses reset while it sits in its wait states.
  task automatic reset_mid(input int d, input logic [11:0] a, input logic w, input logic [31:0] wd);
    xfer(d, a, w, 3'd2, wd, 32'h0, 1'b0, 1'b0);
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    @(negedge clk);
    #2 hrst[d] = 1'b1;
    #1;
    chk($sformatf("dut%0d reset_mid hreadyout", d), 32'(hreadyout[d]), 32'd1);
    chk($sformatf("dut%0d reset_mid hrdata", d), hrdata[d], 32'h0);
    chk($sformatf("dut%0d reset_mid hresp", d), 32'(hresp[d]), 32'd0);
    @(negedge clk);
    #1 hrst[d] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      hrst[d] = 1'b1; hsel[d] = 1'b0; haddr[d] = 12'h0; htrans[d] = 2'b00;
      hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = 32'h0;
    end
    fork
      mon(0);
      mon(1);
    join_none
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset hrdata", d), hrdata[d], 32'h0);
      chk($sformatf("dut%0d reset hreadyout", d), 32'(hreadyout[d]), 32'd1);
      chk($sformatf("dut%0d reset hresp", d), 32'(hresp[d]), 32'd0);
    end
    hrst[0] = 1'b0;
    hrst[1] = 1'b0;
    @(posedge clk);
    #1;

    // Zero wait states
    wr(0, 12'h000, 3'd2, 32'hA5A5A5A5, 1'b0);
    rd(0, 12'h000, 32'hA5A5A5A5, 1'b0);
    wr(0, 12'h008, 3'd2, 32'h12345678, 1'b0);
    wr(0, 12'h009, 3'd0, 32'h0000EF00, 1'b0);
    rd(0, 12'h008, 32'h1234EF78, 1'b0);
    xfer(0, 12'h00C, 1'b1, 3'd2, 32'h87654321, 32'h0, 1'b0, 1'b1);
    rd(0, 12'h00C, 32'h87654321, 1'b0);
    wr(0, 12'h002, 3'd2, 32'hFFFFFFFF, 1'b1);
    rd(0, 12'h000, 32'hA5A5A5A5, 1'b0);
    wr(0, 12'h00E, 3'd1, 32'hBEEF0000, 1'b0);
    rd(0, 12'h00C, 32'hBEEF4321, 1'b0);
    wr(0, 12'h001, 3'd1, 32'h00000000, 1'b1);
    xfer(0, 12'h000, 1'b0, 3'd3, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(0);
    xfer(0, 12'h004, 1'b1, 3'd2, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
    xfer(0, 12'h006, 1'b1, 3'd1, 32'h11110000, 32'h0, 1'b0, 1'b1);
    rd(0, 12'h004, 32'h1111F00D, 1'b0);
`ifdef AHB_SRAM_BOUNDS_CHECK_EN
    rd(0, 12'h400, 32'h0, 1'b1);
`else
    rd(0, 12'h400, 32'hA5A5A5A5, 1'b0);
`endif

    // Two wait states
    wr(1, 12'h000, 3'd2, 32'hA5A5A5A5, 1'b0);
    rd(1, 12'h000, 32'hA5A5A5A5, 1'b0);
    reset_mid(1, 12'h000, 1'b0, 32'h0);
    rd(1, 12'h000, 32'hA5A5A5A5, 1'b0);
    wr(1, 12'h004, 3'd2, 32'hCAFEF00D, 1'b0);
    reset_mid(1, 12'h004, 1'b1, 32'h11111111);
    rd(1, 12'h004, 32'hCAFEF00D, 1'b0);
    xfer(1, 12'h00C, 1'b1, 3'd2, 32'h87654321, 32'h0, 1'b0, 1'b1);
    rd(1, 12'h00C, 32'h87654321, 1'b0);
    wr(1, 12'h002, 3'd2, 32'hFFFFFFFF, 1'b1);
    rd(1, 12'h000, 32'hA5A5A5A5, 1'b0);
    wr(1, 12'h003, 3'd0, 32'h5A000000, 1'b0);
    rd(1, 12'h000, 32'h5AA5A5A5, 1'b0);

    repeat (3) @(negedge clk);
    chk("dut0 outstanding", 32'(q0.size()), 32'd0);
    chk("dut1 outstanding", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
